// File: rtl/timer_pkg.sv
// Shared state encoding and default widths for the interval timer.
`default_nettype none

package timer_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int DEFAULT_WIDTH    = 16;
  localparam int DEFAULT_PS_WIDTH = 8;

endpackage

`default_nettype wire

// File: rtl/counter_sync_clr.sv
// Up-counter with synchronous reset and a synchronous clear that outranks enable.
`default_nettype none

module counter_sync_clr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/interval_timer_ctrl.sv
// Interval timer: prescaler plus main counter, one-shot or periodic single-cycle tick.
`default_nettype none

module interval_timer_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PS_WIDTH = DEFAULT_PS_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                periodic,
  input  logic [WIDTH-1:0]    period,
  input  logic [PS_WIDTH-1:0] prescale,
  output logic                busy,
  output logic                tick,
  output logic [WIDTH-1:0]    count
);

  logic [0:0]          state;
  logic [WIDTH-1:0]    period_q;
  logic [PS_WIDTH-1:0] prescale_q;
  logic                periodic_q;
  logic                tick_q;
  logic [PS_WIDTH-1:0] ps_count;

  logic running;
  logic accept;
  logic step;
  logic terminal;
  logic ps_clear;
  logic main_clear;

  assign running  = (state == ST_RUN);
  assign accept   = start & ~stop;
  assign step     = running & (ps_count == prescale_q);
  assign terminal = step & (count == period_q);

  // Prescaler is held at zero while idle so a fresh start always begins a full step.
  assign ps_clear   = stop | accept | ~running | step;
  assign main_clear = stop | accept | terminal;

  counter_sync_clr #(.WIDTH(PS_WIDTH)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clear  (ps_clear),
    .enable (running),
    .count  (ps_count)
  );

  counter_sync_clr #(.WIDTH(WIDTH)) u_main (
    .clk    (clk),
    .reset  (reset),
    .clear  (main_clear),
    .enable (step),
    .count  (count)
  );

  // Stop and restart both swallow a coincident terminal step.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      period_q   <= '0;
      prescale_q <= '0;
      periodic_q <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      tick_q <= terminal & ~stop & ~start;
      if (stop) begin
        state <= ST_IDLE;
      end else if (start) begin
        state      <= ST_RUN;
        period_q   <= period;
        prescale_q <= prescale;
        periodic_q <= periodic;
      end else if (terminal && !periodic_q) begin
        state <= ST_IDLE;
      end
    end
  end

  assign busy = running;
  assign tick = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_interval_timer_ctrl.sv
// Directed self-checking bench for interval_timer_ctrl (vector table plus multi-cycle sequences).
`default_nettype none

module tb_interval_timer_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, stop, periodic;
  logic [15:0] period;
  logic [7:0]  prescale;
  logic        busy, tick;
  logic [15:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  interval_timer_ctrl #(.WIDTH(16), .PS_WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .period   (period),
    .prescale (prescale),
    .busy     (busy),
    .tick     (tick),
    .count    (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        st;
    logic        sp;
    logic        per;
    logic [15:0] p;
    logic [7:0]  s;
    logic        eb;
    logic        et;
    logic [15:0] ec;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rst, logic st, logic sp, logic per, logic [15:0] p,
                              logic [7:0] s, logic eb, logic et, logic [15:0] ec);
    vec_t v;
    v.rst = rst; v.st = st; v.sp = sp; v.per = per; v.p = p; v.s = s;
    v.eb = eb; v.et = et; v.ec = ec;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive at the falling edge, return 1 time unit after the following rising edge.
  task automatic cyc(logic rst, logic st, logic sp, logic per, logic [15:0] p, logic [7:0] s);
    @(negedge clk);
    reset = rst; start = st; stop = sp; periodic = per; period = p; prescale = s;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(string nm, logic eb, logic et, logic [15:0] ec);
    chk({nm, ".busy"}, {31'd0, busy}, {31'd0, eb});
    chk({nm, ".tick"}, {31'd0, tick}, {31'd0, et});
    chk({nm, ".count"}, {16'd0, count}, {16'd0, ec});
  endtask

  int ticks;
  int last_tick;

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; periodic = 1'b0; period = '0; prescale = '0;

    // rst st sp per  P  S   busy tick count
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    // one-shot P=3 S=0; period input changed mid-run must be ignored
    vq.push_back(mk(0, 1, 0, 0, 3, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 9, 2, 1, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 3, 0, 1, 0, 2));
    vq.push_back(mk(0, 0, 0, 0, 3, 0, 1, 0, 3));
    vq.push_back(mk(0, 0, 0, 0, 3, 0, 0, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 3, 0, 0, 0, 0));
    // start and stop together in IDLE
    vq.push_back(mk(0, 1, 1, 0, 3, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 3, 0, 0, 0, 0));
    // stop on the terminal-step edge
    vq.push_back(mk(0, 1, 0, 0, 1, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 1));
    vq.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    // restart P=5 in the middle of a P=9 interval
    vq.push_back(mk(0, 1, 0, 1, 9, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 9, 0, 1, 0, 1));
    vq.push_back(mk(0, 0, 0, 1, 9, 0, 1, 0, 2));
    vq.push_back(mk(0, 0, 0, 1, 9, 0, 1, 0, 3));
    vq.push_back(mk(0, 1, 0, 1, 5, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 5, 0, 1, 0, 1));
    vq.push_back(mk(0, 0, 0, 1, 5, 0, 1, 0, 2));
    vq.push_back(mk(0, 0, 0, 1, 5, 0, 1, 0, 3));
    vq.push_back(mk(0, 0, 0, 1, 5, 0, 1, 0, 4));
    vq.push_back(mk(0, 0, 0, 1, 5, 0, 1, 0, 5));
    vq.push_back(mk(0, 0, 0, 1, 5, 0, 1, 1, 0));
    vq.push_back(mk(0, 0, 1, 1, 5, 0, 0, 0, 0));
    // restart coinciding with a terminal step: tick discarded
    vq.push_back(mk(0, 1, 0, 0, 1, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 1));
    vq.push_back(mk(0, 1, 0, 0, 1, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0));

    for (int i = 0; i < vq.size(); i++) begin
      cyc(vq[i].rst, vq[i].st, vq[i].sp, vq[i].per, vq[i].p, vq[i].s);
      chk_all($sformatf("vec%0d", i), vq[i].eb, vq[i].et, vq[i].ec);
    end

    // one-shot finished: no further ticks over 20 cycles
    ticks = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(0, 0, 0, 0, 1, 0);
      if (tick) ticks++;
    end
    chk("oneshot_quiet_ticks", ticks, 0);
    chk_all("oneshot_quiet_end", 0, 0, 0);

    // periodic P=2 S=1: count holds 2 cycles per value, tick every 6 cycles
    cyc(0, 1, 0, 1, 2, 1);
    chk_all("per21.k0", 1, 0, 0);
    ticks = 0;
    last_tick = 0;
    for (int k = 1; k <= 30; k++) begin
      cyc(0, 0, 0, 1, 2, 1);
      chk_all($sformatf("per21.k%0d", k), 1, (k % 6) == 0, 16'((k / 2) % 3));
      if (tick) begin
        chk($sformatf("per21.gap%0d", ticks), k - last_tick, 6);
        last_tick = k;
        ticks++;
      end
    end
    chk("per21.ticks", ticks, 5);
    cyc(0, 0, 1, 0, 0, 0);
    chk_all("per21.stop", 0, 0, 0);

    // periodic P=0 S=0: tick every cycle from E1, stop at E10
    cyc(0, 1, 0, 1, 0, 0);
    chk_all("p0.e0", 1, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      cyc(0, 0, 0, 1, 0, 0);
      chk_all($sformatf("p0.e%0d", k), 1, 1, 0);
    end
    cyc(0, 0, 1, 1, 0, 0);
    chk_all("p0.e10_stop", 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk_all("p0.e11", 0, 0, 0);

    // P=7 S=3 periodic with a config change (no start) during RUN, then reset at count=4
    cyc(0, 1, 0, 1, 7, 3);
    chk_all("p7.k0", 1, 0, 0);
    for (int k = 1; k <= 48; k++) begin
      cyc(0, 0, 0, 0, 1, 0);
      chk_all($sformatf("p7.k%0d", k), 1, k == 32, 16'((k % 32) / 4));
    end
    cyc(1, 0, 0, 0, 1, 0);
    chk_all("p7.reset", 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk_all("p7.after_reset", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
